pll_reset_sequencer: RTL and testbench

- Power-up and recovery sequencer for the board clock/reset path, running on the raw board clock ahead of the PLL.
- Drives the PLL reset and waits for a stable lock before releasing the SoC reset.
- Retries PLL bring-up on lock timeout and re-sequences on lock loss.
- An optional heartbeat watchdog, fed from the SoC GPIO, re-resets the CPU only.

---
 rtl/pll_reset_sequencer_if.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Board-side signal bundle of the PLL/SoC reset sequencer.
// The sequencer uses the master modport; the board/PLL/SoC side uses slave.
interface pll_reset_sequencer_if;
    logic       pll_lock;
    logic       heartbeat;
    logic       pll_reset;
    logic       wb_rst;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic       fault;
    logic       wdt_trip;
    logic       status_led;

    modport master (
        input  pll_lock, heartbeat,
        output pll_reset, wb_rst, state, retry_cnt, fault, wdt_trip, status_led
    );

    modport slave (
        output pll_lock, heartbeat,
        input  pll_reset, wb_rst, state, retry_cnt, fault, wdt_trip, status_led
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Board-clock sequencer: PLL reset, lock qualification, SoC reset release,
// lock-loss recovery, retry/fault handling and an optional heartbeat watchdog.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 64,
    parameter int MAX_RETRIES        = 3,
    parameter int WDT_CYCLES         = 0,
    parameter int BLINK_BIT          = 22,
    parameter int CNT_W              = 24
) (
    input  logic                  io_clk,
    input  logic                  io_resetn,
    pll_reset_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_e;

    // Each phase ends on the edge where the counter holds N-1, i.e. the Nth edge in state.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDT_LAST    = CNT_W'(WDT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [1:0]       MAX_R       = 2'(MAX_RETRIES);
    localparam logic             WDT_EN      = (WDT_CYCLES != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] blink_q, blink_d;
    logic [1:0]       retry_q, retry_d;
    logic             lock_m, lock_s;
    logic             hb_m, hb_s, hb_prev;
    logic             hb_edge;
    logic             wdt_trip_q, wdt_trip_d;
    logic             pll_reset_q, wb_rst_q, fault_q, led_q;

    assign hb_edge = hb_s ^ hb_prev;
    assign blink_d = blink_q + CNT_ONE;

    always_ff @(posedge io_clk or negedge io_resetn) begin
        if (!io_resetn) begin
            lock_m  <= 1'b0;
            lock_s  <= 1'b0;
            hb_m    <= 1'b0;
            hb_s    <= 1'b0;
            hb_prev <= 1'b0;
        end else begin
            lock_m  <= bus.pll_lock;
            lock_s  <= lock_m;
            hb_m    <= bus.heartbeat;
            hb_s    <= hb_m;
            hb_prev <= hb_s;
        end
    end

    always_ff @(posedge io_clk or negedge io_resetn) begin
        if (!io_resetn) begin
            state_q <= PLL_RST;
            phase_q <= '0;
            blink_q <= '0;
            retry_q <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            retry_q <= retry_d;
        end
    end

    // In RUN the phase counter doubles as the watchdog: a heartbeat edge clears it.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q + CNT_ONE;
        retry_d    = retry_q;
        wdt_trip_d = wdt_trip_q;
        case (state_q)
            PLL_RST: begin
                if (phase_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (phase_q == TIMEOUT_LAST) begin
                    if (retry_q == MAX_R) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lock_s)                    state_d = WAIT_LOCK;
                else if (phase_q == STABLE_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                end else if (phase_q == HOLD_LAST) begin
                    state_d = RUN;
                    retry_d = 2'd0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                end else if (hb_edge) begin
                    phase_d = '0;
                end else if (WDT_EN && (phase_q == WDT_LAST)) begin
                    state_d    = HOLD;
                    wdt_trip_d = 1'b1;
                end
            end
            FAULT: begin
                phase_d = phase_q;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase
        if (state_d != state_q) phase_d = '0;
    end

    always_ff @(posedge io_clk or negedge io_resetn) begin
        if (!io_resetn) begin
            pll_reset_q <= 1'b1;
            wb_rst_q    <= 1'b1;
            fault_q     <= 1'b0;
            wdt_trip_q  <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            pll_reset_q <= (state_d == PLL_RST) || (state_d == FAULT);
            wb_rst_q    <= (state_d != RUN);
            fault_q     <= (state_d == FAULT);
            wdt_trip_q  <= wdt_trip_d;
            led_q       <= (state_d == RUN) || ((state_d == FAULT) && blink_d[BLINK_BIT]);
        end
    end

    assign bus.state      = state_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.pll_reset  = pll_reset_q;
    assign bus.wb_rst     = wb_rst_q;
    assign bus.fault      = fault_q;
    assign bus.wdt_trip   = wdt_trip_q;
    assign bus.status_led = led_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer: a phase/dwell-time reference model
// predicts every cycle's outputs into a queue that an independent monitor drains.
module tb_pll_reset_sequencer;

  localparam int PLL_RST_CYCLES     = 4;
  localparam int LOCK_TIMEOUT       = 20;
  localparam int LOCK_STABLE_CYCLES = 8;
  localparam int RST_HOLD_CYCLES    = 4;
  localparam int MAX_RETRIES        = 2;
  localparam int WDT_CYCLES         = 50;
  localparam int BLINK_BIT          = 22;
  localparam int CNT_W              = 24;

  // Phase numbers as the debug port reports them.
  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_HOLD = 3, P_RUN = 4, P_FAULT = 5;

  logic io_clk = 1'b0;
  logic io_resetn;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES), .RST_HOLD_CYCLES(RST_HOLD_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .WDT_CYCLES(WDT_CYCLES),
    .BLINK_BIT(BLINK_BIT), .CNT_W(CNT_W)
  ) dut (
    .io_clk(io_clk),
    .io_resetn(io_resetn),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 io_clk = ~io_clk;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  event push_ev;
  int checks = 0;
  int errors = 0;
  logic [9:0] mon_exp, mon_act;

  // ---------------- reference model ----------------
  int m_state, m_dwell, m_retry, m_quiet, m_cycles;
  bit m_trip;
  bit lock_line[$];
  bit hb_line[$];
  int hb_period, hb_ctr;

  function automatic void model_reset();
    m_state  = P_RST;
    m_dwell  = 0;
    m_retry  = 0;
    m_quiet  = 0;
    m_cycles = 0;
    m_trip   = 1'b0;
    lock_line = '{1'b0, 1'b0};
    hb_line   = '{1'b0, 1'b0, 1'b0};
  endfunction

  // One clock edge: lock is seen two edges late, a heartbeat edge three edges late.
  function automatic void model_step(bit lock_in, bit hb_in);
    bit lock_seen, hb_seen;
    int nxt;
    lock_seen = lock_line[0];
    hb_seen   = (hb_line[0] != hb_line[1]);
    void'(lock_line.pop_front());
    lock_line.push_back(lock_in);
    void'(hb_line.pop_front());
    hb_line.push_back(hb_in);
    m_cycles++;
    m_dwell++;
    nxt = m_state;
    case (m_state)
      P_RST:    if (m_dwell == PLL_RST_CYCLES) nxt = P_WAIT;
      P_WAIT: begin
        if (lock_seen) nxt = P_STABLE;
        else if (m_dwell == LOCK_TIMEOUT) begin
          if (m_retry == MAX_RETRIES) nxt = P_FAULT;
          else begin
            m_retry++;
            nxt = P_RST;
          end
        end
      end
      P_STABLE: begin
        if (!lock_seen) nxt = P_WAIT;
        else if (m_dwell == LOCK_STABLE_CYCLES) nxt = P_HOLD;
      end
      P_HOLD: begin
        if (!lock_seen) nxt = P_RST;
        else if (m_dwell == RST_HOLD_CYCLES) begin
          nxt = P_RUN;
          m_retry = 0;
        end
      end
      P_RUN: begin
        if (!lock_seen) nxt = P_RST;
        else if (hb_seen) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet == WDT_CYCLES) begin
            nxt = P_HOLD;
            m_trip = 1'b1;
          end
        end
      end
      default: nxt = m_state;
    endcase
    if (nxt != m_state) begin
      m_dwell = 0;
      m_quiet = 0;
    end
    m_state = nxt;
  endfunction

  // Packed as {state, retry_cnt, pll_reset, wb_rst, fault, wdt_trip, status_led}.
  function automatic logic [9:0] model_out();
    logic led;
    led = (m_state == P_RUN) || ((m_state == P_FAULT) && (((m_cycles >> BLINK_BIT) & 1) == 1));
    return {3'(m_state), 2'(m_retry),
            1'((m_state == P_RST) || (m_state == P_FAULT)),
            1'(m_state != P_RUN),
            1'(m_state == P_FAULT),
            m_trip, led};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_exp();
    exp_q.push_back(model_out());
    -> push_ev;
  endtask

  task automatic set_hb(int period);
    hb_period = period;
    hb_ctr    = 0;
  endtask

  task automatic tick();
    @(posedge io_clk);
    if (io_resetn) model_step(bus.pll_lock, bus.heartbeat);
    push_exp();
    @(negedge io_clk);
    if (hb_period > 0) begin
      hb_ctr++;
      if (hb_ctr >= hb_period) begin
        bus.heartbeat = ~bus.heartbeat;
        hb_ctr = 0;
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic run_until(int target, int budget, string tag);
    int c;
    c = 0;
    while (m_state != target && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (m_state != target) begin
      errors++;
      $display("FAIL reach_%s: model phase %0d after %0d cycles, wanted %0d", tag, m_state, c, target);
    end
  endtask

  // Asserted between edges so the monitor sees the asynchronous effect before the next edge.
  task automatic do_reset(int n);
    io_resetn = 1'b0;
    model_reset();
    push_exp();
    run(n);
    io_resetn = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(push_ev);
      #1;
      while (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {bus.state, bus.retry_cnt, bus.pll_reset, bus.wb_rst,
                   bus.fault, bus.wdt_trip, bus.status_led};
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL outputs t=%0t got=%b expected=%b (state,retry,pll_reset,wb_rst,fault,wdt_trip,led)",
                   $time, mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    io_resetn     = 1'b1;
    bus.pll_lock  = 1'b0;
    bus.heartbeat = 1'b0;
    set_hb(0);
    model_reset();
    #2;
    do_reset(3);

    // normal bring-up with heartbeats inside the watchdog window
    run(PLL_RST_CYCLES + $urandom_range(0, 12));
    bus.pll_lock = 1'b1;
    set_hb(30);
    run_until(P_RUN, 100, "run_bringup");
    run(150);

    // heartbeat stops: watchdog trip, HOLD, back to RUN
    set_hb(0);
    run_until(P_HOLD, 100, "wdt_hold");
    run_until(P_RUN, 20, "wdt_rerun");
    set_hb($urandom_range(5, 45));
    run(200);

    // lock loss in RUN and full re-sequence
    bus.pll_lock = 1'b0;
    run($urandom_range(3, 30));
    bus.pll_lock = 1'b1;
    run_until(P_RUN, 300, "relock");
    run(20);

    // one-cycle lock glitch during STABLE
    set_hb(0);
    do_reset(2);
    bus.pll_lock = 1'b1;
    run_until(P_STABLE, 100, "stable");
    run(5);
    bus.pll_lock = 1'b0;
    run(1);
    bus.pll_lock = 1'b1;
    run_until(P_RUN, 100, "glitch_run");
    run(10);

    // lock never comes: retries then FAULT, which lock cannot leave
    do_reset(2);
    bus.pll_lock = 1'b0;
    run_until(P_FAULT, 200, "fault");
    run(30);
    bus.pll_lock = 1'b1;
    run(40);

    // asynchronous reset while in HOLD
    do_reset(2);
    run_until(P_HOLD, 100, "hold");
    run($urandom_range(0, 2));
    do_reset(3);
    run_until(P_RUN, 100, "after_async");

    // random lock/heartbeat segments with occasional resets
    for (int seg = 0; seg < 40; seg++) begin
      bus.pll_lock = ($urandom_range(0, 3) != 0);
      set_hb($urandom_range(0, 3) == 0 ? 0 : $urandom_range(3, 60));
      run($urandom_range(1, 80));
      if ($urandom_range(0, 12) == 0) do_reset($urandom_range(1, 3));
    end

    run(2);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
